// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: DEPTH-entry circular buffer with valid/ready on both sides,
// redirect flush and occupancy report. Define PIPE_STAGE_BUF_PERF_EN for stall/peak counters.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              redirect_flush,
  output logic [CNT_W-1:0]  count,
  output logic [31:0]       stall_cycles,
  output logic [CNT_W-1:0]  hi_water
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head_ptr, tail_ptr;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic              push, pop;

  // Wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[head_ptr] : '0;
  assign count     = count_q;

  assign push = in_valid  & in_ready  & ~redirect_flush;
  assign pop  = out_valid & out_ready & ~redirect_flush;

  always_comb begin
    count_nxt = count_q;
    if (redirect_flush)   count_nxt = '0;
    else if (push & ~pop) count_nxt = count_q + 1'b1;
    else if (pop & ~push) count_nxt = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else if (redirect_flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push) tail_ptr <= ptr_inc(tail_ptr);
      if (pop)  head_ptr <= ptr_inc(head_ptr);
      count_q <= count_nxt;
    end
  end

  // Payload storage is deliberately unreset; out_data masks it while empty.
  always_ff @(posedge clock) begin
    if (push) mem[tail_ptr] <= in_data;
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0]      stall_q;
  logic [CNT_W-1:0] hi_q;

  // Survive flush; only reset clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      hi_q    <= '0;
    end else begin
      if (in_valid & ~in_ready & (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 1'b1;
      if (count_nxt > hi_q) hi_q <= count_nxt;
    end
  end

  assign stall_cycles = stall_q;
  assign hi_water     = hi_q;
`else
  assign stall_cycles = '0;
  assign hi_water     = '0;
`endif

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised, elastic successor to the fixed-field pipeline register between backend stages. It carries an opaque payload of DATA_W bits through a DEPTH-entry circular buffer with a valid/ready handshake on both sides. It supports redirect flush and reports occupancy. It sits between decode/issue/execute/mem/wb stages wherever a stage must absorb back-pressure without a global stall wire.

Parameters:
- DATA_W, 64, payload width in bits (>=1); the upstream stage packs its fields into this vector.
- DEPTH, 2, number of buffer entries (>=2, need not be a power of 2).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clock  in  1  stage clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  buffer can accept this cycle.
- in_data  in  DATA_W  payload.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  DATA_W  head payload.
- redirect_flush  in  1  discard all entries.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- stall_cycles  out  32  performance counter; see Optional Feature.
- hi_water  out  CNT_W  peak occupancy; see Optional Feature.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, on ports clock and reset_n.
- Reset: head_ptr=0, tail_ptr=0, count=0, out_valid=0, out_data=0, in_ready=1, stall_cycles=0, hi_water=0.
  - Storage array is not reset.
  - reset_n asserted mid-operation drops all entries immediately.
- Combinational outputs:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_data = mem[head_ptr] when out_valid, else all zeros.
- push = in_valid & in_ready & ~redirect_flush.
  - On push: mem[tail_ptr] <= in_data; tail_ptr advances.
- pop = out_valid & out_ready & ~redirect_flush.
  - On pop: head_ptr advances.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0; otherwise it increments by 1. No power-of-2 assumption.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: data pushed at edge N is visible on out_valid/out_data after edge N; minimum 1 cycle. There is no combinational in->out bypass.
- Full: in_ready=0, so no push occurs even if a pop happens in the same cycle. in_ready rises the cycle after the pop. Throughput is 1/cycle when DEPTH>=2 and downstream is not stalling.
- Empty: out_valid=0. A pop attempt is ignored. Simultaneous push is accepted; count becomes 1.
- Push and pop in the same cycle at 0<count<DEPTH: both occur and count is unchanged.
- redirect_flush=1 at an edge:
  - head_ptr, tail_ptr and count go to 0.
  - A same-cycle push and pop are both suppressed.
  - Flush has priority over everything except reset.
  - in_ready is not gated by flush. Upstream must treat its offer as discarded.
- Data integrity: strict FIFO order; payload bits are unmodified.

Optional Feature:
- Macro: PIPE_STAGE_BUF_PERF_EN.
- Defined:
  - stall_cycles increments by 1 on every edge where in_valid & ~in_ready, saturating at 32'hFFFF_FFFF.
  - hi_water updates to the next count whenever that exceeds hi_water.
  - Neither counter is cleared by redirect_flush; only reset clears them.
- Undefined: stall_cycles and hi_water are tied to 0 and no counter flops are instantiated. Ports remain present in both builds.

Test Plan:
- DEPTH=2, DATA_W=64, out_ready=1: push 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 on consecutive cycles starting one cycle after the first push; count never exceeds 1.
- DEPTH=3, out_ready=0: push 4 words -> first 3 accepted, count=3, in_ready=0. Raise out_ready for 1 cycle with in_valid=1 -> pop of word 0 only, no push that cycle; in_ready=1 next cycle.
- DEPTH=3 (non-power-of-2): 10 push/pop cycles with count held at 2 -> pointers wrap 2->0; output order matches input order exactly.
- count=2 with push and pop asserted and redirect_flush=1 -> next cycle count=0, out_valid=0, out_data=0; the pushed word never appears.
- Assert reset_n low asynchronously mid-stream with count=2 -> out_valid=0, count=0 before the next clock edge; operation resumes normally after release.
- PIPE_STAGE_BUF_PERF_EN defined, DEPTH=2, in_valid=1, out_ready=0 for 10 cycles -> hi_water=2, stall_cycles=8. Flush, then check both values are unchanged. Undefined build: both outputs read 0 throughout.
